// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and defaults for the bit-serial datapath
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LEN_W = $clog2(DEFAULT_WIDTH);

    typedef logic [DEFAULT_LEN_W-1:0] len_t;

    // Operand word as exchanged between the feeder and the result deserializer
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        len_t                     len_m1;
    } operand_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - loadable right-shift register, bit 0 is the serial output
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   load     : capture d (takes priority over shift)
//   shift    : shift right by one, zero fill
//   d        : parallel load value
//   q0       : current bit 0
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= d;
        end else if (shift) begin
            sh <= {1'b0, sh[WIDTH-1:1]};
        end
    end

    assign q0 = sh[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - parallel-to-serial operand front end for the bit-serial adder
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : operand word offered
//   in_ready      : word accepted this cycle if in_valid
//   in_a, in_b    : operands, bit 0 sent first
//   in_len_m1     : bits to send minus 1
//   en            : downstream permits a bit this cycle
//   vld, a, b     : serial bit pair, valid when vld
//   last          : current pair ends the operation
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LEN_W-1:0] in_len_m1,
    input  logic             en,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last
);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_sat;
    logic             busy;
    logic             accept;
    logic             advance;

    // Out-of-range lengths clamp to a full-width operation
    assign len_sat = (int'(in_len_m1) > WIDTH - 1) ? LEN_W'(WIDTH - 1) : in_len_m1;

    assign busy     = (state == SHIFT);
    assign vld      = busy & en;
    assign last     = vld & (cnt == '0);
    // Ready on the final bit lets the next word follow with no bubble
    assign in_ready = !busy | last;
    assign accept   = in_valid & in_ready;
    assign advance  = vld & !last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= len_sat;
        end else if (advance) begin
            cnt   <= cnt - LEN_W'(1);
        end else if (last) begin
            state <= IDLE;
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (advance),
        .d     (in_a),
        .q0    (a)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (advance),
        .d     (in_b),
        .q0    (b)
    );

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - directed self-checking bench for serial_operand_feeder
module tb_serial_operand_feeder;

    localparam int W = 4;
    localparam int LW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [LW-1:0] in_len_m1;
    logic          en;
    logic          vld;
    logic          a;
    logic          b;
    logic          last;
    logic [4:0]    obs;

    int tests = 0;
    int fails = 0;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_len_m1 (in_len_m1),
        .en        (en),
        .vld       (vld),
        .a         (a),
        .b         (b),
        .last      (last)
    );

    always #5 clk = ~clk;

    // {vld, last, a, b, in_ready}
    assign obs = {vld, last, a, b, in_ready};

    always @(posedge clk) begin
        if (!rst && in_valid) begin
            assert (int'(in_len_m1) < W);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [LW-1:0] vl);
        in_valid  = 1'b1;
        in_a      = va;
        in_b      = vb;
        in_len_m1 = vl;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_len_m1 = '0; en = 1'b0;
        next(); next();
        rst = 1'b0;
        #1;
        tests++;
        if (obs !== 5'b00001) begin
            fails++; $display("FAIL reset_en0 got %b exp %b", obs, 5'b00001);
        end
        next(); en = 1'b1; #1;
        tests++;
        if (obs !== 5'b00001) begin
            fails++; $display("FAIL reset_en1 got %b exp %b", obs, 5'b00001);
        end
    endtask

    task automatic test_single();
        logic [4:0] e [5];
        logic [3:0] sum_exp;
        logic       c;
        e = '{5'b10010, 5'b10110, 5'b10100, 5'b11001, 5'b00001};
        sum_exp = 4'b1001;
        c = 1'b0;
        next(); offer(4'b0110, 4'b0011, 2'd3); en = 1'b1; #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL single_ready got %b exp 1", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            next(); in_valid = 1'b0; #1;
            tests++;
            if (obs !== e[i]) begin
                fails++; $display("FAIL single[%0d] got %b exp %b", i, obs, e[i]);
            end
            if (i < 4) begin
                tests++;
                if ((a ^ b ^ c) !== sum_exp[i]) begin
                    fails++; $display("FAIL single_sum[%0d] got %b exp %b", i, a ^ b ^ c, sum_exp[i]);
                end
                c = (a & b) | (a & c) | (b & c);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e [7];
        e = '{5'b10010, 5'b10110, 5'b10100, 5'b11001, 5'b10110, 5'b11001, 5'b00001};
        next(); offer(4'b0110, 4'b0011, 2'd3); en = 1'b1;
        next(); offer(4'b0001, 4'b0001, 2'd1); #1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                next();
                if (i == 4) in_valid = 1'b0;
                #1;
            end
            tests++;
            if (obs !== e[i]) begin
                fails++; $display("FAIL b2b[%0d] got %b exp %b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_stalls();
        logic [4:0] e [8];
        logic       ep [8];
        e  = '{5'b10010, 5'b00110, 5'b10110, 5'b00100, 5'b10100, 5'b00000, 5'b11001, 5'b00001};
        ep = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        next(); offer(4'b0110, 4'b0011, 2'd3); en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next(); in_valid = 1'b0; en = ep[i]; #1;
            tests++;
            if (obs !== e[i]) begin
                fails++; $display("FAIL stall[%0d] got %b exp %b", i, obs, e[i]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_len0();
        next(); offer(4'b1111, 4'b0000, 2'd0); en = 1'b1;
        next(); in_valid = 1'b0; #1;
        tests++;
        if (obs !== 5'b11101) begin
            fails++; $display("FAIL len0_bit got %b exp %b", obs, 5'b11101);
        end
        next(); #1;
        tests++;
        if (obs !== 5'b00101) begin
            fails++; $display("FAIL len0_idle got %b exp %b", obs, 5'b00101);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] e [9];
        e = '{5'b10010, 5'b10110, 5'b10100, 5'b11001,
              5'b10000, 5'b10100, 5'b10010, 5'b11111, 5'b00111};
        next(); offer(4'b0110, 4'b0011, 2'd3); en = 1'b1;
        next(); offer(4'b1010, 4'b1100, 2'd3); #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                next();
                if (i == 4) in_valid = 1'b0;
                #1;
            end
            tests++;
            if (obs !== e[i]) begin
                fails++; $display("FAIL bp[%0d] got %b exp %b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [4:0] e [4];
        e = '{5'b10010, 5'b10110, 5'b10100, 5'b11001};
        next(); offer(4'b0110, 4'b0011, 2'd3); en = 1'b1;
        next(); in_valid = 1'b0;
        next();
        next(); rst = 1'b1; #1;
        tests++;
        if (obs !== 5'b10100) begin
            fails++; $display("FAIL rstmid_bit2 got %b exp %b", obs, 5'b10100);
        end
        next(); rst = 1'b0; #1;
        tests++;
        if (obs !== 5'b00001) begin
            fails++; $display("FAIL rstmid_after got %b exp %b", obs, 5'b00001);
        end
        offer(4'b0110, 4'b0011, 2'd3);
        for (int i = 0; i < 4; i++) begin
            next(); in_valid = 1'b0; #1;
            tests++;
            if (obs !== e[i]) begin
                fails++; $display("FAIL rstmid_fresh[%0d] got %b exp %b", i, obs, e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stalls();
        test_len0();
        test_backpressure();
        test_reset_midop();
        next();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
